// File: rtl/fc_binary_neuron.sv
// Binary-weight fully connected output neuron.
// A frame of BEATS beats, each carrying LANES signed activations, is reduced
// to one signed dot product against a serially loaded 1-bit weight vector
// (1 = +1, 0 = -1). All arithmetic wraps modulo 2^DW.
// The reset input keeps its historical name rstn but is active-high.
module fc_binary_neuron #(
    parameter int LANES = 6,
    parameter int BEATS = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          ivalid,
    input  logic [DW-1:0] din_0,
    input  logic [DW-1:0] din_1,
    input  logic [DW-1:0] din_2,
    input  logic [DW-1:0] din_3,
    input  logic [DW-1:0] din_4,
    input  logic [DW-1:0] din_5,
    input  logic          weight,
    input  logic          weight_en,
    output logic          ovalid,
    output logic [DW-1:0] dout
);

    localparam int NW = LANES * BEATS;
    localparam int PW = $clog2(NW);
    localparam int CW = $clog2(BEATS);

    logic [NW-1:0]    wreg;
    logic [PW-1:0]    wptr;
    logic [CW-1:0]    beat_cnt;
    logic [DW-1:0]    acc;

    logic [DW-1:0]    lane [LANES];
    logic [DW-1:0]    term [LANES];
    logic [PW-1:0]    wbase;
    logic [LANES-1:0] wbeat;
    logic [DW-1:0]    beat_sum;
    logic             beat_accept;
    logic             last_beat;

    assign lane[0] = din_0;
    assign lane[1] = din_1;
    assign lane[2] = din_2;
    assign lane[3] = din_3;
    assign lane[4] = din_4;
    assign lane[5] = din_5;

    // A simultaneous weight write wins; the beat is dropped entirely.
    assign beat_accept = ivalid & ~weight_en;
    assign last_beat   = (beat_cnt == CW'(BEATS - 1));

    // Weights for beat k live at indices LANES*k .. LANES*k+LANES-1.
    assign wbase = PW'(beat_cnt) * PW'(LANES);
    assign wbeat = wreg[wbase +: LANES];

    // Each lane contributes +din or -din depending on its weight bit.
    for (genvar j = 0; j < LANES; j++) begin : g_term
        assign term[j] = wbeat[j] ? lane[j] : (~lane[j] + DW'(1));
    end

    // Combinational reduction of the lane terms for the current beat.
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_sum = beat_sum + term[i];
        end
    end

    // Serial weight store with a wrapping write pointer.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wreg <= '0;
            wptr <= '0;
        end else if (weight_en) begin
            wreg[wptr] <= weight;
            wptr       <= (wptr == PW'(NW - 1)) ? '0 : wptr + PW'(1);
        end
    end

    // Beat counter and running sum; the final beat publishes the result.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            beat_cnt <= '0;
            acc      <= '0;
        end else if (beat_accept) begin
            if (last_beat) begin
                beat_cnt <= '0;
                acc      <= '0;
            end else begin
                beat_cnt <= beat_cnt + CW'(1);
                acc      <= acc + beat_sum;
            end
        end
    end

    // Result register and one-cycle valid pulse; dout holds between frames.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            ovalid <= 1'b0;
            dout   <= '0;
        end else begin
            ovalid <= 1'b0;
            if (beat_accept && last_beat) begin
                ovalid <= 1'b1;
                dout   <= acc + beat_sum;
            end
        end
    end

endmodule

// File: tb/tb_fc_binary_neuron.sv
// Directed bench for fc_binary_neuron with hand-computed expected results.
module tb_fc_binary_neuron;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ivalid;
    logic [31:0] din_0, din_1, din_2, din_3, din_4, din_5;
    logic        weight;
    logic        weight_en;
    logic        ovalid;
    logic [31:0] dout;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int p0;

    fc_binary_neuron dut (
        .clk       (clk),
        .rstn      (rstn),
        .ivalid    (ivalid),
        .din_0     (din_0),
        .din_1     (din_1),
        .din_2     (din_2),
        .din_3     (din_3),
        .din_4     (din_4),
        .din_5     (din_5),
        .weight    (weight),
        .weight_en (weight_en),
        .ovalid    (ovalid),
        .dout      (dout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ovalid === 1'b1) pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic we, input logic w,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] a3, input logic [31:0] a4, input logic [31:0] a5);
        @(negedge clk);
        ivalid = iv; weight_en = we; weight = w;
        din_0 = a0; din_1 = a1; din_2 = a2; din_3 = a3; din_4 = a4; din_5 = a5;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic beat(input logic [31:0] v);
        drive(1'b1, 1'b0, 1'b0, v, v, v, v, v, v);
    endtask

    task automatic load_w(input logic [191:0] p);
        for (int i = 0; i < 192; i++) drive(1'b0, 1'b1, p[i], 0, 0, 0, 0, 0, 0);
    endtask

    task automatic frame_const(input logic [31:0] v);
        for (int k = 0; k < 32; k++) beat(v);
    endtask

    // Call right after the 32nd beat has been driven.
    task automatic check_frame(input string tag, input logic [31:0] exp);
        idle();
        #1;
        check({tag, "_ovalid"}, {31'd0, ovalid}, 32'd1);
        check({tag, "_dout"}, dout, exp);
        check({tag, "_pulses"}, pulses - p0, 1);
        idle();
        #1;
        check({tag, "_ovalid_drop"}, {31'd0, ovalid}, 32'd0);
        check({tag, "_dout_hold"}, dout, exp);
    endtask

    initial begin
        rstn = 1'b1;
        ivalid = 1'b0; weight_en = 1'b0; weight = 1'b0;
        din_0 = 0; din_1 = 0; din_2 = 0; din_3 = 0; din_4 = 0; din_5 = 0;
        repeat (3) @(negedge clk);
        check("reset_ovalid", {31'd0, ovalid}, 32'd0);
        check("reset_dout", dout, 32'd0);
        rstn = 1'b0;

        // Weights after reset are all -1.
        p0 = pulses;
        frame_const(32'd1);
        check_frame("reset_weights", 32'hFFFF_FF40);

        p0 = pulses;
        load_w({192{1'b1}});
        frame_const(32'd1);
        check_frame("all_plus", 32'd192);

        p0 = pulses;
        load_w({192{1'b0}});
        frame_const(32'd5);
        check_frame("all_minus", 32'hFFFF_FC40);

        p0 = pulses;
        load_w({96{2'b01}});
        for (int k = 0; k < 32; k++) drive(1'b1, 1'b0, 1'b0, 1, 2, 3, 4, 5, 6);
        check_frame("alternating", 32'hFFFF_FFA0);

        p0 = pulses;
        load_w({192{1'b1}});
        for (int k = 0; k < 32; k++) begin
            beat(32'(k));
            if (k < 31) begin
                idle();
                #1;
                if (k == 15) check("gap_no_early_ovalid", pulses - p0, 0);
            end
        end
        check_frame("gapped", 32'd2976);

        // A 33rd beat opens a new frame without output.
        p0 = pulses;
        beat(32'd7);
        repeat (3) idle();
        #1;
        check("extra_beat_no_pulse", pulses - p0, 0);
        check("extra_beat_dout_hold", dout, 32'd2976);

        // Asynchronous reset mid-frame.
        for (int k = 0; k < 10; k++) beat(32'd1);
        idle();
        @(posedge clk);
        #2 rstn = 1'b1;
        #1;
        check("async_reset_dout", dout, 32'd0);
        check("async_reset_ovalid", {31'd0, ovalid}, 32'd0);
        @(negedge clk);
        rstn = 1'b0;

        // Reload +1 weights; a beat colliding with a weight write is ignored.
        p0 = pulses;
        load_w({192{1'b1}});
        for (int k = 0; k < 32; k++) begin
            beat(32'd1);
            if (k == 12) drive(1'b1, 1'b1, 1'b1, 1000, 1000, 1000, 1000, 1000, 1000);
        end
        check_frame("after_reset_prio", 32'd192);

        // Pointer wrap: six extra bits overwrite indices 0..5 with +1.
        p0 = pulses;
        load_w({192{1'b0}});
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0);
        frame_const(32'd1);
        check_frame("wptr_wrap", 32'hFFFF_FF4C);

        // Wrapping overflow.
        p0 = pulses;
        load_w({192{1'b1}});
        for (int k = 0; k < 32; k++) begin
            if (k < 2) drive(1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 0, 0, 0, 0, 0);
            else beat(32'd0);
        end
        check_frame("overflow_wrap", 32'hFFFF_FFFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fc_binary_neuron.md
Name: fc_binary_neuron

Overview:
- Binary-weight fully connected output neuron for the BNN datapath. Consumes a 6x4x4 feature map (192 signed 32-bit activations) as 32 beats of 6 lanes. Produces one signed 32-bit dot product against 192 stored 1-bit weights.
- Weights are loaded serially before inference.
- Sits after the final conv/pool stage.

Parameters:
- LANES, 6, activations per input beat.
- BEATS, 32, beats per frame; total weights = LANES*BEATS = 192.
- DW, 32, activation and result width (two's complement).

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous, active-high reset; despite the name, 1 = reset.
- ivalid  in  1  one beat of din_0..din_5 valid this cycle.
- din_0..din_5  in  32 each  signed activations; din_j is lane j.
- weight  in  1  serial weight bit; 1 means +1, 0 means -1.
- weight_en  in  1  weight bit valid this cycle.
- ovalid  out  1  single-cycle pulse: dout holds a new result.
- dout  out  32  signed neuron result.

Behaviour:
- Reset (rstn=1, asynchronous): clears all of the following to 0.
  - Weight register (all 192 bits = 0, i.e. all -1).
  - Weight write pointer.
  - Beat counter and accumulator.
  - ovalid and dout.
- Weight load: each rising edge with weight_en=1 stores weight into index wptr, then increments wptr.
  - The first bit after reset is index 0.
  - After index 191, wptr wraps to 0; further bits overwrite from index 0.
  - Weights persist across frames until reset or overwrite.
- Weight/activation mapping: beat k (0..31), lane j (0..5) uses weight index 6k+j.
- Beat processing: each rising edge with ivalid=1 and weight_en=0 computes beat_sum = sum over j of (w ? +din_j : -din_j).
  - All arithmetic is signed 32-bit, wrapping modulo 2^32; there is no saturation.
- Accumulation on an accepted beat:
  - If the beat counter is below 31: acc <= acc + beat_sum; counter increments.
  - If the beat counter is 31: dout <= acc + beat_sum; ovalid <= 1 for exactly the next cycle; acc <= 0; counter <= 0.
- Latency: ovalid and dout appear on the clock edge that accepts the 32nd beat. Both are visible to the bench on the following rising edge.
- ovalid is 0 in every other cycle. dout holds its last result until the next frame completes.
- Beats may be non-consecutive; idle cycles (ivalid=0) do not affect acc or the counter.
- Priority: if ivalid and weight_en are both 1 in the same cycle, the weight write is performed and the beat is ignored (not counted, not accumulated).
- An extra beat after a completed frame starts a new frame. A partial frame produces no output.
- Reset mid-frame discards the partial sum and all weights.
- Implementation: registered beat counter (5 bits), weight pointer (8 bits), 192-bit weight store, 32-bit accumulator. A purely combinational 6-term adder per beat is acceptable; there is no pipelining requirement beyond the latency above.

Test Plan:
- Load 192 weights of 1, then 32 beats with every din = 1 -> one ovalid pulse, dout = 192.
- Load 192 weights of 0, then 32 beats with every din = 5 -> dout = -960.
- Load alternating weights (index even = 1, odd = 0), then every din_j = j+1 -> per beat (1-2+3-4+5-6) = -3, so dout = -96.
- All weights 1, beats separated by idle cycles (ivalid 1-0-1-0), din = beat index k on all lanes -> dout = 6*(0+...+31) = 2976, single ovalid pulse after the 32nd beat. A 33rd beat produces no ovalid.
- Assert rstn after 10 beats of din = 1, release, then send 32 beats of din = 1 with weights reloaded as all 1 -> dout = 192, not 252. Outputs read 0 during reset.
- All weights 1, din_0 = 32'h7FFFFFFF with other lanes 0 on beats 0 and 1, zeros on the remaining beats -> dout wraps to -2 (32'hFFFFFFFE).
